// File: rtl/mul_share_scheduler_pkg.sv
// Shared types and helpers for the time-shared sequential multiplier scheduler.
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Requester id width, never narrower than one bit
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_share_scheduler_if.sv
// Job request / response bundle between requesters and the multiplier scheduler.
interface mul_share_scheduler_if
    import mul_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int ID_W = id_w(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       gnt;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_p;

    modport master (
        output req, req_a, req_b, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req, req_a, req_b, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_p
    );

endinterface

// File: rtl/mul_share_scheduler_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module mul_rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    // Rotating priority search starting at the pointer
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            int  pos;
            logic hit;
            pos        = (int'(i_ptr) + k) % N_REQ;
            hit        = !o_any && i_req[pos];
            o_gnt[pos] = hit;
            o_idx      = hit ? pos[ID_W-1:0] : o_idx;
            o_any      = o_any | hit;
        end
    end

endmodule

// File: rtl/mul_share_scheduler.sv
// Arbitrates N_REQ multiply jobs onto one repeated-addition datapath and returns
// each product with its owner id over a valid/ready response.
module mul_share_scheduler
    import mul_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int SWAP_MIN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_share_scheduler_if.slave bus,
    output logic                 busy,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic                 lda,
    output logic                 ldb,
    output logic                 ldp,
    output logic                 clrp,
    output logic                 decb,
    input  logic                 mul_zero,
    input  logic [2*WIDTH-1:0]   mul_p
);

    localparam int ID_W = id_w(N_REQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_rsp_p;

    logic [N_REQ-1:0]   w_arb_gnt;
    logic [ID_W-1:0]    w_arb_idx;
    logic               w_arb_any;
    logic [WIDTH-1:0]   w_a_slice;
    logic [WIDTH-1:0]   w_b_slice;
    logic               w_swap;
    logic               w_accept;
    logic               w_capture;

    mul_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    assign w_a_slice = bus.req_a[int'(w_arb_idx)*WIDTH +: WIDTH];
    assign w_b_slice = bus.req_b[int'(w_arb_idx)*WIDTH +: WIDTH];
    // Putting the smaller operand in B minimises the number of add cycles
    assign w_swap    = (SWAP_MIN != 0) && (w_b_slice > w_a_slice);

    // Next-state and datapath strobe decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        lda         = 1'b0;
        ldb         = 1'b0;
        clrp        = 1'b0;
        ldp         = 1'b0;
        decb        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_any && !rst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                lda         = 1'b1;
                ldb         = 1'b1;
                clrp        = 1'b1;
                w_state_nxt = CALC;
            end
            CALC: begin
                if (mul_zero) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    ldp         = 1'b1;
                    decb        = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job latch, round-robin pointer and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rsp_p  <= '0;
            r_rsp_id <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= w_swap ? w_b_slice : w_a_slice;
                r_b   <= w_swap ? w_a_slice : w_b_slice;
                r_id  <= w_arb_idx;
                r_ptr <= (int'(w_arb_idx) == N_REQ - 1) ? '0 : w_arb_idx + 1'b1;
            end
            if (w_capture) begin
                r_rsp_p  <= mul_p;
                r_rsp_id <= r_id;
            end
        end
    end

    assign bus.gnt       = (r_state == IDLE && !rst) ? w_arb_gnt : '0;
    assign bus.rsp_valid = (r_state == DONE);
    assign bus.rsp_p     = r_rsp_p;
    assign bus.rsp_id    = r_rsp_id;
    assign busy          = (r_state != IDLE);
    assign mul_a         = r_a;
    assign mul_b         = r_b;

endmodule

// File: tb/tb_mul_share_scheduler.sv
// Directed scoreboard bench: two schedulers (SWAP_MIN 1 and 0), each driving its own
// A/B/P repeated-addition datapath.
module tb_mul_share_scheduler;
    import mul_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        int id;
        int p;
        int lat;
        int nb;
        int la;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_share_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus0 ();
    mul_share_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus1 ();

    logic         busy0, lda0, ldb0, ldp0, clrp0, decb0, zero0;
    logic [W-1:0] ma0, mb0, dpa0, dpb0;
    logic [2*W-1:0] dpp0;
    logic         busy1, lda1, ldb1, ldp1, clrp1, decb1, zero1;
    logic [W-1:0] ma1, mb1, dpa1, dpb1;
    logic [2*W-1:0] dpp1;

    mul_share_scheduler #(.N_REQ(N), .WIDTH(W), .SWAP_MIN(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .mul_a(ma0), .mul_b(mb0),
        .lda(lda0), .ldb(ldb0), .ldp(ldp0), .clrp(clrp0), .decb(decb0),
        .mul_zero(zero0), .mul_p(dpp0)
    );

    mul_share_scheduler #(.N_REQ(N), .WIDTH(W), .SWAP_MIN(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .mul_a(ma1), .mul_b(mb1),
        .lda(lda1), .ldb(ldb1), .ldp(ldp1), .clrp(clrp1), .decb(decb1),
        .mul_zero(zero1), .mul_p(dpp1)
    );

    assign zero0 = (dpb0 == '0);
    assign zero1 = (dpb1 == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dpa0 <= '0; dpb0 <= '0; dpp0 <= '0;
        end else begin
            if (lda0) dpa0 <= ma0;
            if (ldb0) dpb0 <= mb0; else if (decb0) dpb0 <= dpb0 - 8'd1;
            if (clrp0) dpp0 <= '0; else if (ldp0) dpp0 <= dpp0 + {8'd0, dpa0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dpa1 <= '0; dpb1 <= '0; dpp1 <= '0;
        end else begin
            if (lda1) dpa1 <= ma1;
            if (ldb1) dpb1 <= mb1; else if (decb1) dpb1 <= dpb1 - 8'd1;
            if (clrp1) dpp1 <= '0; else if (ldp1) dpp1 <= dpp1 + {8'd0, dpa1};
        end
    end

    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    exp_t sb[$];
    int   gorder[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        opa[i] = a;
        opb[i] = b;
        bus0.req_a[i*W +: W] = a;
        bus0.req_b[i*W +: W] = b;
    endtask

    // Called at posedge+1 with requests already raised; runs until all jobs are answered
    task automatic service(input int budget, input int stall, input logic [N-1:0] inject);
        int n = 0;
        int gcyc = 0;
        int nldp = 0;
        int w = 0;
        bit seen = 1'b0;
        bit hs_prev = 1'b0;
        bit load_next = 1'b0;
        bit inj_left = (inject != '0);
        bit inj_arm = 1'b0;
        logic [N-1:0] clr = '0;
        logic [2*W-1:0] hp = '0;
        logic [1:0] hid = '0;
        exp_t e;
        e = '{id: 0, p: 0, lat: 0, nb: 0, la: 0};
        forever begin
            bus0.req = bus0.req & ~clr;
            clr = '0;
            if (inj_arm) begin
                bus0.req = bus0.req | inject;
                inj_arm = 1'b0;
            end
            #1;
            if (hs_prev && bus0.req != '0) chk("gnt_after_hs", bus0.gnt != '0, 1);
            hs_prev = 1'b0;
            if (load_next) begin
                chk("load_strobes", {lda0, ldb0, clrp0, ldp0, decb0}, 5'b11100);
                chk("load_mul_a", ma0, e.la);
                chk("load_mul_b", mb0, e.nb);
                load_next = 1'b0;
            end
            if (bus0.gnt != '0) begin
                chk("gnt_onehot", $onehot(bus0.gnt), 1);
                for (int i = 0; i < N; i++) if (bus0.gnt[i]) w = i;
                e.id  = w;
                e.p   = int'(opa[w]) * int'(opb[w]);
                e.nb  = (opb[w] > opa[w]) ? int'(opa[w]) : int'(opb[w]);
                e.la  = (opb[w] > opa[w]) ? int'(opb[w]) : int'(opa[w]);
                e.lat = 3 + e.nb;
                sb.push_back(e);
                gorder.push_back(w);
                gcyc = cyc;
                nldp = 0;
                clr = bus0.gnt;
                load_next = 1'b1;
                if (inj_left) begin
                    inj_arm = 1'b1;
                    inj_left = 1'b0;
                end
            end
            if (ldp0) nldp++;
            if (bus0.rsp_valid) begin
                chk("strobes_done", {lda0, ldb0, clrp0, ldp0, decb0}, 5'b00000);
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", cyc - gcyc, sb[0].lat);
                    chk("add_cycles", nldp, sb[0].nb);
                    hp = bus0.rsp_p;
                    hid = bus0.rsp_id;
                end else begin
                    chk("stall_p", bus0.rsp_p, hp);
                    chk("stall_id", bus0.rsp_id, hid);
                    chk("stall_busy", busy0, 1);
                    chk("stall_gnt", bus0.gnt, 0);
                end
                if (stall > 0) begin
                    stall--;
                    bus0.rsp_ready = 1'b0;
                end else begin
                    bus0.rsp_ready = 1'b1;
                    e = sb.pop_front();
                    chk("rsp_p", bus0.rsp_p, e.p);
                    chk("rsp_id", bus0.rsp_id, e.id);
                    seen = 1'b0;
                    hs_prev = 1'b1;
                end
            end
            if (bus0.req == '0 && sb.size() == 0 && !busy0 && !inj_arm && !inj_left) break;
            n++;
            if (n > budget) begin
                chk("timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int c0;
        int nv;
        logic [N*W-1:0] t;
        bus0.req = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.rsp_ready = 1'b1;
        bus1.req = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 8'd0, 8'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_valid", bus0.rsp_valid, 0);
        chk("rst_strobes", {lda0, ldb0, clrp0, ldp0, decb0}, 0);
        chk("rst_p", bus0.rsp_p, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: 8*5
        set_op(0, 8'd8, 8'd5);
        bus0.req = 4'b0001;
        service(50, 0, '0);
        // 2: 3*200 swapped into B=3
        set_op(1, 8'd3, 8'd200);
        bus0.req = 4'b0010;
        service(50, 0, '0);
        // 3: zero operand
        set_op(2, 8'd7, 8'd0);
        bus0.req = 4'b0100;
        service(50, 0, '0);

        // 2b: no swap on the second instance
        t = '0; t[1*W +: W] = 8'd3;   bus1.req_a = t;
        t = '0; t[1*W +: W] = 8'd200; bus1.req_b = t;
        bus1.req = 4'b0010;
        #1;
        chk("noswap_gnt", bus1.gnt, 4'b0010);
        c0 = cyc;
        @(posedge clk);
        #1;
        bus1.req = '0;
        for (int k = 0; k < 400; k++) begin
            if (bus1.rsp_valid) break;
            @(posedge clk);
            #1;
        end
        chk("noswap_lat", cyc - c0, 203);
        chk("noswap_p", bus1.rsp_p, 600);
        chk("noswap_id", bus1.rsp_id, 1);
        @(posedge clk);
        #1;
        chk("noswap_idle", busy1, 0);

        // 4: round robin from a fresh pointer
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'd2);
        gorder.delete();
        bus0.req = 4'b1111;
        service(100, 0, '0);
        chk("rr_count", gorder.size(), 4);
        for (int i = 0; i < 4; i++) chk("rr_order", gorder[i], i);
        gorder.delete();
        bus0.req = 4'b0101;
        service(100, 0, '0);
        chk("rr2_count", gorder.size(), 2);
        chk("rr2_first", gorder[0], 0);
        chk("rr2_second", gorder[1], 2);

        // 5: consumer stalls 4 cycles while requester 3 waits
        set_op(0, 8'd2, 8'd3);
        set_op(3, 8'd5, 8'd4);
        gorder.delete();
        bus0.req = 4'b0001;
        service(100, 4, 4'b1000);
        chk("stall_order", gorder.size(), 2);
        chk("stall_second", gorder[1], 3);

        // 6: reset in the middle of a long job
        set_op(0, 8'd255, 8'd255);
        bus0.req = 4'b0001;
        @(posedge clk);
        #1;
        bus0.req = '0;
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_calc", ldp0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy0, 0);
        chk("arst_strobes", {lda0, ldb0, clrp0, ldp0, decb0}, 0);
        chk("arst_mul", {ma0, mb0}, 0);
        chk("arst_rsp", {bus0.rsp_valid, bus0.rsp_id, bus0.rsp_p}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nv = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus0.rsp_valid || busy0) nv++;
        end
        chk("no_rsp_after_rst", nv, 0);
        set_op(0, 8'd7, 8'd6);
        bus0.req = 4'b0001;
        service(50, 0, '0);
        set_op(0, 8'd255, 8'd255);
        bus0.req = 4'b0001;
        service(400, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
